// File: rtl/fifo_chk_pkg.sv
// fifo_chk_pkg: shared state encoding and default widths for the FIFO read checker
package fifo_chk_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, GAP = 2'd2} state_t;
endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: synchronous-clear incrementing counter that holds at all-ones
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: bursty FIFO drainer that checks an incrementing data stream with zero latency
module fifo_rd_checker
  import fifo_chk_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  en,
  input  logic [7:0]            cfg_burst,
  input  logic [7:0]            cfg_gap,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  err_flag,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_got,
  output logic [1:0]            state
);
  state_t cur, nxt;
  logic [7:0] bcnt, bcnt_nxt, gcnt, gcnt_nxt, blen, blen_nxt, glen, glen_nxt;
  logic [DATA_WIDTH-1:0] exp_q;
  logic done, miss;
  assign state = cur;
  assign miss = rinc && (rdata != exp_q);
  always_comb begin
    rinc = (cur == READ) && en && !rempty && !rrst;
    done = rinc && (blen != 8'd0) && (bcnt + 8'd1 == blen);
    nxt = cur;
    bcnt_nxt = bcnt;
    gcnt_nxt = gcnt;
    blen_nxt = blen;
    glen_nxt = glen;
    if (!en) begin
      nxt = IDLE;
      bcnt_nxt = '0;
      gcnt_nxt = '0;
    end else begin
      case (cur)
        READ:
          if (done && cfg_gap != 8'd0) begin
            nxt = GAP;
            bcnt_nxt = '0;
            gcnt_nxt = '0;
            glen_nxt = cfg_gap;
          end else if (done) begin
            bcnt_nxt = '0;
            blen_nxt = cfg_burst;
          end else if (rinc) begin
            bcnt_nxt = bcnt + 8'd1;
          end
        GAP:
          if (gcnt + 8'd1 == glen) begin
            nxt = READ;
            gcnt_nxt = '0;
            blen_nxt = cfg_burst;
          end else begin
            gcnt_nxt = gcnt + 8'd1;
          end
        default: begin
          nxt = READ;
          bcnt_nxt = '0;
          gcnt_nxt = '0;
          blen_nxt = cfg_burst;
        end
      endcase
    end
  end
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cur <= IDLE;
      bcnt <= '0;
      gcnt <= '0;
      blen <= '0;
      glen <= '0;
      exp_q <= '0;
      err_flag <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      cur <= nxt;
      bcnt <= bcnt_nxt;
      gcnt <= gcnt_nxt;
      blen <= blen_nxt;
      glen <= glen_nxt;
      if (rinc) exp_q <= rdata + 1'b1;
      if (miss) err_flag <= 1'b1;
      if (miss && !err_flag) begin
        first_err_exp <= exp_q;
        first_err_got <= rdata;
      end
    end
  end
  sat_cnt #(.W(CNT_WIDTH)) u_rd_cnt (
    .clk(rclk),
    .rst(rrst),
    .clr(1'b0),
    .inc(rinc),
    .q(rd_cnt)
  );
  sat_cnt #(.W(CNT_WIDTH)) u_err_cnt (
    .clk(rclk),
    .rst(rrst),
    .clr(1'b0),
    .inc(miss),
    .q(err_cnt)
  );
endmodule

// File: tb/tb_fifo_rd_checker.sv
// tb_fifo_rd_checker: directed self-checking bench with a queue-based FIFO model
module tb_fifo_rd_checker;
  logic rclk = 1'b0, rrst = 1'b1, en = 1'b0, rempty = 1'b1;
  logic [7:0] cfg_burst = 8'd0, cfg_gap = 8'd0, rdata = 8'd0;
  logic rinc, err_flag;
  logic [7:0] rd_cnt, err_cnt, first_err_exp, first_err_got;
  logic [1:0] state, prev;
  logic [7:0] q[$];
  logic p, pe, e;
  int errors = 0, checks = 0, pops = 0, gaps, hi, first, last, n;

  fifo_rd_checker #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .rclk(rclk), .rrst(rrst), .en(en), .cfg_burst(cfg_burst), .cfg_gap(cfg_gap),
    .rempty(rempty), .rdata(rdata), .rinc(rinc), .rd_cnt(rd_cnt), .err_cnt(err_cnt),
    .err_flag(err_flag), .first_err_exp(first_err_exp), .first_err_got(first_err_got),
    .state(state)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic refresh();
    rempty = (q.size() == 0);
    rdata = rempty ? 8'd0 : q[0];
  endtask

  task automatic push(input int a, input int b);
    for (int i = a; i <= b; i++) q.push_back(8'(i));
    refresh();
  endtask

  task automatic step();
    #1;
    p = rinc;
    pe = rempty;
    chk("rinc_while_empty", int'(p & pe), 0);
    @(posedge rclk);
    #1;
    if (p) begin
      if (q.size() > 0) void'(q.pop_front());
      pops++;
    end
    refresh();
    @(negedge rclk);
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while (q.size() > 0 && k < maxc) begin
      step();
      k++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    en = 1'b0;
    q.delete();
    refresh();
    step();
    rrst = 1'b0;
    pops = 0;
  endtask

  initial begin
    @(negedge rclk);
    do_reset();
    chk("reset_rd_cnt", rd_cnt, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_err_flag", err_flag, 0);
    chk("reset_state", state, 0);
    chk("reset_rinc", rinc, 0);

    push(0, 19);
    cfg_burst = 8'd0;
    en = 1'b1;
    hi = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (p) begin
        hi++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("cont_pops", hi, 20);
    chk("cont_contiguous", last - first, 19);
    chk("cont_rd_cnt", rd_cnt, 20);
    chk("cont_err_cnt", err_cnt, 0);
    chk("cont_rinc_empty", rinc, 0);

    do_reset();
    push(0, 11);
    cfg_burst = 8'd4;
    cfg_gap = 8'd3;
    en = 1'b1;
    gaps = 0;
    prev = 2'd0;
    for (int i = 0; i < 19; i++) begin
      step();
      e = (i >= 1 && i <= 4) || (i >= 8 && i <= 11) || (i >= 15 && i <= 18);
      chk("burst_pattern", p, e);
      if (i < 18 && state == 2'd2 && prev != 2'd2) gaps++;
      prev = state;
    end
    chk("burst_gap_visits", gaps, 2);
    chk("burst_rd_cnt", rd_cnt, 12);
    chk("burst_err_cnt", err_cnt, 0);

    do_reset();
    cfg_burst = 8'd0;
    cfg_gap = 8'd0;
    push(0, 2);
    push(4, 6);
    en = 1'b1;
    drain(20);
    chk("skip_err_cnt", err_cnt, 1);
    chk("skip_err_flag", err_flag, 1);
    chk("skip_first_exp", first_err_exp, 3);
    chk("skip_first_got", first_err_got, 4);
    chk("skip_rd_cnt", rd_cnt, 6);
    push(9, 9);
    drain(10);
    chk("second_err_cnt", err_cnt, 2);
    chk("second_keeps_exp", first_err_exp, 3);
    chk("second_keeps_got", first_err_got, 4);

    do_reset();
    push(0, 255);
    push(0, 1);
    en = 1'b1;
    drain(300);
    chk("wrap_err_cnt", err_cnt, 0);
    chk("wrap_rd_cnt_sat", rd_cnt, 255);

    do_reset();
    push(0, 9);
    cfg_burst = 8'd8;
    cfg_gap = 8'd2;
    en = 1'b1;
    n = 0;
    while (pops < 5 && n < 20) begin
      step();
      n++;
    end
    chk("rst_pre_pops", pops, 5);
    rrst = 1'b1;
    step();
    chk("rst_no_pop", p, 0);
    chk("rst_fifo_left", q.size(), 5);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_first_exp", first_err_exp, 0);
    chk("rst_first_got", first_err_got, 0);
    chk("rst_state", state, 0);
    rrst = 1'b0;
    drain(20);
    chk("rst_post_err_cnt", err_cnt, 1);
    chk("rst_post_first_exp", first_err_exp, 0);
    chk("rst_post_first_got", first_err_got, 5);
    chk("rst_post_rd_cnt", rd_cnt, 5);

    do_reset();
    push(0, 9);
    cfg_burst = 8'd0;
    cfg_gap = 8'd0;
    en = 1'b1;
    n = 0;
    while (pops < 3 && n < 20) begin
      step();
      n++;
    end
    en = 1'b0;
    #1;
    chk("endrop_rinc_same_cycle", rinc, 0);
    step();
    chk("endrop_state_idle", state, 0);
    chk("endrop_no_pop", pops, 3);
    en = 1'b1;
    drain(20);
    chk("endrop_err_cnt", err_cnt, 0);
    chk("endrop_err_flag", err_flag, 0);
    chk("endrop_rd_cnt", rd_cnt, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
